vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates the screen and char RAMs between the video fetcher and a CPU port.
// Video always wins while active; a committed CPU access completes regardless.
module vram_arbiter #(
  parameter int RAM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_active,
  input  logic [9:0]  vid_sram_addr,
  input  logic [9:0]  vid_cram_addr,
  output logic [7:0]  vid_sram_data,
  output logic [7:0]  vid_cram_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_wait_n,
  output logic [9:0]  sram_addr,
  output logic        sram_we,
  output logic [7:0]  sram_wdata,
  input  logic [7:0]  sram_q,
  output logic [9:0]  cram_addr,
  output logic        cram_we,
  output logic [7:0]  cram_wdata,
  input  logic [7:0]  cram_q,
  output logic [15:0] wait_cycles
);

  typedef enum logic [2:0] {IDLE, BLOCKED, ACCESS, LAT, DONE, RELEASE} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

  state_t      state_q, state_d;
  logic [10:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        sram_we_q, sram_we_d;
  logic        cram_we_q, cram_we_d;
  logic [15:0] wait_q, wait_d;

  logic stall;
  logic start;
  logic cpu_owns;

  // Held in reset the CPU is never stalled, even with a request pending.
  assign stall    = reset_n && cpu_req &&
                    (state_q inside {IDLE, BLOCKED, ACCESS, LAT});
  assign start    = cpu_req && !vid_active && (state_q inside {IDLE, BLOCKED});
  assign cpu_owns = state_q inside {ACCESS, LAT};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    lat_cnt_d = lat_cnt_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    sram_we_d = 1'b0;
    cram_we_d = 1'b0;
    wait_d    = (stall && wait_q != 16'hFFFF) ? wait_q + 16'd1 : wait_q;

    // The write strobe is registered so it lines up exactly with ACCESS.
    if (start) begin
      addr_d    = cpu_addr;
      we_d      = cpu_we;
      wdata_d   = cpu_wdata;
      sram_we_d = cpu_we && !cpu_addr[10];
      cram_we_d = cpu_we && cpu_addr[10];
    end

    case (state_q)
      IDLE: begin
        if (start)        state_d = ACCESS;
        else if (cpu_req) state_d = BLOCKED;
      end
      BLOCKED: begin
        if (!cpu_req)     state_d = IDLE;
        else if (start)   state_d = ACCESS;
      end
      ACCESS: begin
        lat_cnt_d = 2'd0;
        if (we_q) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          state_d = LAT;
        end
      end
      LAT: begin
        if (lat_cnt_q == LAT_LAST) begin
          rdata_d = addr_q[10] ? cram_q : sram_q;
          ack_d   = 1'b1;
          state_d = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      DONE:    state_d = RELEASE;
      RELEASE: if (!cpu_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      lat_cnt_q <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      sram_we_q <= 1'b0;
      cram_we_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      lat_cnt_q <= lat_cnt_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      sram_we_q <= sram_we_d;
      cram_we_q <= cram_we_d;
      wait_q    <= wait_d;
    end
  end

  assign sram_addr     = cpu_owns ? addr_q[9:0] : vid_sram_addr;
  assign cram_addr     = cpu_owns ? addr_q[9:0] : vid_cram_addr;
  assign sram_we       = sram_we_q;
  assign cram_we       = cram_we_q;
  assign sram_wdata    = wdata_q;
  assign cram_wdata    = wdata_q;
  assign vid_sram_data = sram_q;
  assign vid_cram_data = cram_q;
  assign cpu_rdata     = rdata_q;
  assign cpu_ack       = ack_q;
  assign cpu_wait_n    = !stall;
  assign wait_cycles   = wait_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: CPU transactions are predicted from the
// timing rules (ack cycle, ownership window, stall count) against model RAMs.
module tb_vram_arbiter;

  localparam int RAM_LAT = 2;

  logic        clk;
  logic        reset_n;
  logic        vid_active;
  logic [9:0]  vid_sram_addr, vid_cram_addr;
  logic [7:0]  vid_sram_data, vid_cram_data;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_wait_n;
  logic [9:0]  sram_addr, cram_addr;
  logic        sram_we, cram_we;
  logic [7:0]  sram_wdata, cram_wdata, sram_q, cram_q;
  logic [15:0] wait_cycles;

  int          checks;
  int          fails;
  int          modelWait;
  logic [7:0]  lastRdata;
  logic [7:0]  refS [1024];
  logic [7:0]  refC [1024];
  logic        ramInit;

  logic [7:0]  memS [1024];
  logic [7:0]  memC [1024];
  logic [7:0]  pipeS [RAM_LAT];
  logic [7:0]  pipeC [RAM_LAT];

  vram_arbiter #(.RAM_LAT(RAM_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .vid_active(vid_active),
    .vid_sram_addr(vid_sram_addr), .vid_cram_addr(vid_cram_addr),
    .vid_sram_data(vid_sram_data), .vid_cram_data(vid_cram_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .sram_addr(sram_addr), .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_q(sram_q),
    .cram_addr(cram_addr), .cram_we(cram_we), .cram_wdata(cram_wdata), .cram_q(cram_q),
    .wait_cycles(wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seed(input int i, input bit c);
    return 8'((i * 29 + 7) ^ (c ? 8'h5A : 8'h00));
  endfunction

  function automatic logic [15:0] satWait();
    return (modelWait > 65535) ? 16'hFFFF : 16'(modelWait);
  endfunction

  // Synchronous RAMs with RAM_LAT cycles of read latency.
  always @(posedge clk) begin
    if (!ramInit) begin
      for (int i = 0; i < 1024; i++) begin
        memS[i] <= seed(i, 1'b0);
        memC[i] <= seed(i, 1'b1);
      end
    end else begin
      if (sram_we) memS[sram_addr] <= sram_wdata;
      if (cram_we) memC[cram_addr] <= cram_wdata;
    end
    pipeS[0] <= memS[sram_addr];
    pipeC[0] <= memC[cram_addr];
    for (int i = 1; i < RAM_LAT; i++) begin
      pipeS[i] <= pipeS[i-1];
      pipeC[i] <= pipeC[i-1];
    end
  end

  assign sram_q = pipeS[RAM_LAT-1];
  assign cram_q = pipeC[RAM_LAT-1];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One CPU transaction: video blocks for blk cycles, request held hold cycles
  // past ack; race raises vid_active the cycle after the access is committed.
  task automatic applyStimulus(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                               input int blk, input int hold, input bit race);
    int expAck, ackAt, acks, total;
    bit owned, reqOn;
    expAck = blk + 2 + (we ? 0 : RAM_LAT);
    total  = expAck + hold + 3;
    ackAt  = -1;
    acks   = 0;
    for (int c = 0; c < total; c++) begin
      reqOn         = (c <= expAck + hold);
      cpu_req       = reqOn;
      cpu_we        = we;
      cpu_addr      = addr;
      cpu_wdata     = wdata;
      vid_active    = (c < blk) || (race && c >= blk + 2 && c <= expAck + 1);
      vid_sram_addr = 10'($urandom);
      vid_cram_addr = 10'($urandom);
      @(negedge clk);
      owned = (c >= blk + 1) && (c <= expAck - 1);
      checkOutput("sram_addr", sram_addr, owned ? addr[9:0] : vid_sram_addr);
      checkOutput("cram_addr", cram_addr, owned ? addr[9:0] : vid_cram_addr);
      checkOutput("sram_we", sram_we, we && !addr[10] && c == blk + 1);
      checkOutput("cram_we", cram_we, we && addr[10] && c == blk + 1);
      checkOutput("cpu_wait_n", cpu_wait_n, !(reqOn && c < expAck));
      checkOutput("vid_data", {vid_sram_data, vid_cram_data}, {sram_q, cram_q});
      if (cpu_ack) begin
        acks++;
        ackAt = c;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("ack_cycle", ackAt, expAck);
    checkOutput("ack_count", acks, 1);
    if (we) begin
      if (addr[10]) refC[addr[9:0]] = wdata;
      else          refS[addr[9:0]] = wdata;
      checkOutput("mem_write", addr[10] ? memC[addr[9:0]] : memS[addr[9:0]], wdata);
    end else begin
      lastRdata = addr[10] ? refC[addr[9:0]] : refS[addr[9:0]];
    end
    checkOutput("cpu_rdata", cpu_rdata, lastRdata);
    modelWait += expAck;
    checkOutput("wait_cycles", wait_cycles, satWait());
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_wait_n"}, cpu_wait_n, 1'b1);
    checkOutput({tag, "_ack"}, cpu_ack, 1'b0);
    checkOutput({tag, "_rdata"}, cpu_rdata, 8'h00);
    checkOutput({tag, "_wait"}, wait_cycles, 16'h0000);
    checkOutput({tag, "_we"}, {sram_we, cram_we}, 2'b00);
    checkOutput({tag, "_saddr"}, sram_addr, vid_sram_addr);
    checkOutput({tag, "_caddr"}, cram_addr, vid_cram_addr);
  endtask

  task automatic resetDuringLat();
    int acks;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h405; cpu_wdata = 8'h00; vid_active = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2 reset_n = 1'b0;
    vid_sram_addr = 10'h0C3; vid_cram_addr = 10'h31C;
    #1 checkResetState("rst_lat");
    @(negedge clk);
    checkResetState("rst_hold");
    cpu_req = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    modelWait = 0;
    lastRdata = 8'h00;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    checkOutput("rst_no_ack", acks, 0);
    checkOutput("rst_wait", wait_cycles, 16'h0000);
    @(posedge clk);
    #1;
  endtask

  task automatic saturation();
    bit seen;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'h3C; vid_active = 1'b1;
    for (int c = 0; c < 65540; c++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("sat_blocked", wait_cycles, 16'hFFFF);
    @(posedge clk);
    #1 vid_active = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (cpu_ack) seen = 1'b1;
    end
    checkOutput("sat_ack", seen, 1'b1);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_final", wait_cycles, 16'hFFFF);
  endtask

  initial begin
    checks = 0; fails = 0; modelWait = 0; lastRdata = 8'h00; ramInit = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      refS[i] = seed(i, 1'b0);
      refC[i] = seed(i, 1'b1);
    end
    reset_n = 1'b0; vid_active = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h7FF; cpu_wdata = 8'hFF;
    vid_sram_addr = 10'h155; vid_cram_addr = 10'h2AA;
    #12 checkResetState("reset");
    repeat (2) @(posedge clk);
    ramInit = 1'b1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed transactions");
    applyStimulus(1'b1, 11'h005, 8'hA5, 0, 0, 1'b0);
    applyStimulus(1'b0, 11'h005, 8'h00, 0, 0, 1'b0);
    applyStimulus(1'b0, 11'h40A, 8'h00, 40, 0, 1'b0);
    applyStimulus(1'b1, 11'h40B, 8'h5C, 0, 10, 1'b0);
    applyStimulus(1'b0, 11'h40B, 8'h00, 3, 10, 1'b0);
    applyStimulus(1'b0, 11'h005, 8'h00, 0, 2, 1'b1);
    applyStimulus(1'b0, 11'h40A, 8'h00, 4, 1, 1'b1);

    $display("[TB] reset during LAT");
    resetDuringLat();
    applyStimulus(1'b0, 11'h005, 8'h00, 0, 0, 1'b0);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      logic        rwe;
      logic [10:0] raddr;
      int          rblk;
      rwe   = 1'($urandom_range(0, 1));
      raddr = {1'($urandom_range(0, 1)), 6'd0, 4'($urandom_range(0, 15))};
      rblk  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      applyStimulus(rwe, raddr, 8'($urandom), rblk, int'($urandom_range(0, 3)),
                    !rwe && ($urandom_range(0, 3) == 0));
    end

    $display("[TB] wait counter saturation");
    saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
